// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter: FSM state and the per-requester access command.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes next.
module miriscv_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/miriscv_dmem_arbiter.sv
// Data-memory arbiter between the core LSU (m0) and a DMA/debug port (m1).
// One access in flight at a time; grant is combinational in IDLE, completion after RD_LATENCY cycles.
module miriscv_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [BE_W-1:0] m0_be_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [BE_W-1:0] m1_be_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            core_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  arb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;  // last granted requester; also the owner while in WAIT
  logic [1:0]       arb_gnt;
  logic             arb_any;
  mem_cmd_t         m0_cmd;
  mem_cmd_t         m1_cmd;
  mem_cmd_t         sel_cmd;

  assign m0_cmd = {m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i};
  assign m1_cmd = {m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i};

  miriscv_rr_arb2 u_rr (
    .req  ({m1_req_i, m0_req_i}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  assign arb_any = (state_q == IDLE) && (arb_gnt != 2'b00);

  // Output decode: grant/strobe in IDLE, completion when the latency counter has drained.
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    sel_cmd     = '0;
    if (arb_any) begin
      m0_gnt_o  = arb_gnt[0];
      m1_gnt_o  = arb_gnt[1];
      mem_req_o = 1'b1;
      sel_cmd   = arb_gnt[1] ? m1_cmd : m0_cmd;
    end else if ((state_q == WAIT) && (cnt_q == '0)) begin
      m0_rvalid_o = ~last_q;
      m1_rvalid_o = last_q;
      rdata_o     = mem_rdata_i;
    end
    mem_we_o     = sel_cmd.we;
    mem_be_o     = sel_cmd.be;
    mem_addr_o   = sel_cmd.addr;
    mem_wdata_o  = sel_cmd.wdata;
    core_stall_o = m0_req_i & ~m0_rvalid_o;
  end

  // Reset leaves m1 as last owner so m0 wins the first tie.
  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
            last_q  <= arb_gnt[1];
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_dmem_arbiter.sv
// Directed bench for miriscv_dmem_arbiter: instance a uses RD_LATENCY=1, instance b RD_LATENCY=3.
module tb_miriscv_dmem_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

  logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_stall, a_mreq, a_mwe;
  logic [3:0]  a_mbe;
  logic [31:0] a_rdata, a_maddr, a_mwdata;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_stall, b_mreq, b_mwe;
  logic [3:0]  b_mbe;
  logic [31:0] b_rdata, b_maddr, b_mwdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miriscv_dmem_arbiter u_a (
    .clk_i(clk), .arstn_i(arstn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(a_gnt0), .m0_rvalid_o(a_rv0),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(a_gnt1), .m1_rvalid_o(a_rv1),
    .rdata_o(a_rdata), .core_stall_o(a_stall),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_rdata_i(mem_rdata)
  );

  miriscv_dmem_arbiter #(.RD_LATENCY(3)) u_b (
    .clk_i(clk), .arstn_i(arstn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(b_gnt0), .m0_rvalid_o(b_rv0),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(b_gnt1), .m1_rvalid_o(b_rv1),
    .rdata_o(b_rdata), .core_stall_o(b_stall),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_rdata_i(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    arstn = 1'b1;
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = 32'hCAFE_0001;

    // Held in reset: everything quiet
    repeat (2) @(posedge clk);
    #1; settle;
    check("rst_mreq", a_mreq, 0);
    check("rst_rv0", a_rv0, 0);
    check("rst_rv1", a_rv1, 0);
    check("rst_stall", a_stall, 0);
    check("rst_b_mreq", b_mreq, 0);
    arstn = 1'b0;

    // First tie after reset goes to m0, then m1
    tick;
    m0_req = 1; m0_addr = 32'h10; m0_be = 4'hF;
    m1_req = 1; m1_addr = 32'h20; m1_be = 4'hF;
    settle;
    check("t1_c0_gnt0", a_gnt0, 1);
    check("t1_c0_gnt1", a_gnt1, 0);
    check("t1_c0_mreq", a_mreq, 1);
    check("t1_c0_maddr", a_maddr, 32'h10);
    check("t1_c0_mwe", a_mwe, 0);
    check("t1_c0_stall", a_stall, 1);
    tick; settle;
    check("t1_c1_rv0", a_rv0, 1);
    check("t1_c1_rv1", a_rv1, 0);
    check("t1_c1_rdata", a_rdata, 32'hCAFE_0001);
    check("t1_c1_mreq", a_mreq, 0);
    check("t1_c1_maddr", a_maddr, 0);
    check("t1_c1_gnt1", a_gnt1, 0);
    check("t1_c1_stall", a_stall, 0);
    tick;
    m0_req = 0; m0_addr = '0;
    settle;
    check("t1_c2_gnt1", a_gnt1, 1);
    check("t1_c2_gnt0", a_gnt0, 0);
    check("t1_c2_maddr", a_maddr, 32'h20);
    tick; settle;
    check("t1_c3_rv1", a_rv1, 1);
    check("t1_c3_rv0", a_rv0, 0);
    tick;
    m1_req = 0; m1_addr = '0;
    settle;
    check("t1_idle_mreq", a_mreq, 0);

    // Both hold requests for 8 cycles: m0,m1 alternate every 2 cycles
    tick;
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      settle;
      check($sformatf("t2_gnt0_%0d", i), a_gnt0, 32'((i % 4) == 0));
      check($sformatf("t2_gnt1_%0d", i), a_gnt1, 32'((i % 4) == 2));
      check($sformatf("t2_rv0_%0d", i), a_rv0, 32'((i % 4) == 1));
      check($sformatf("t2_rv1_%0d", i), a_rv1, 32'((i % 4) == 3));
      check($sformatf("t2_mreq_%0d", i), a_mreq, 32'((i % 2) == 0));
      check($sformatf("t2_stall_%0d", i), a_stall, 32'((i % 4) != 1));
      tick;
    end
    m0_req = 0; m1_req = 0;
    settle;
    check("t2_idle_mreq", a_mreq, 0);

    // m0 byte write: fields on the bus for exactly one cycle
    tick;
    m0_req = 1; m0_we = 1; m0_be = 4'b0100; m0_addr = 32'h30; m0_wdata = 32'hAABB_CCDD;
    settle;
    check("t3_gnt0", a_gnt0, 1);
    check("t3_mwe", a_mwe, 1);
    check("t3_mbe", a_mbe, 32'h4);
    check("t3_mwdata", a_mwdata, 32'hAABB_CCDD);
    check("t3_maddr", a_maddr, 32'h30);
    tick; settle;
    check("t3_c1_mreq", a_mreq, 0);
    check("t3_c1_mwe", a_mwe, 0);
    check("t3_c1_mbe", a_mbe, 0);
    check("t3_c1_mwdata", a_mwdata, 0);
    check("t3_c1_rv0", a_rv0, 1);
    tick;
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
    arstn = 1'b1;
    settle;
    arstn = 1'b0;

    // RD_LATENCY=3: m1 read, m0 arrives mid-flight and waits
    tick;
    m1_req = 1; m1_addr = 32'h44; m1_be = 4'hF;
    settle;
    check("t4_c0_mreq", b_mreq, 1);
    check("t4_c0_gnt1", b_gnt1, 1);
    check("t4_c0_maddr", b_maddr, 32'h44);
    check("t4_c0_mbe", b_mbe, 32'hF);
    check("t4_c0_mwe", b_mwe, 0);
    check("t4_c0_mwdata", b_mwdata, 0);
    tick;
    m0_req = 1; m0_addr = 32'h50; m0_be = 4'hF;
    settle;
    check("t4_c1_gnt0", b_gnt0, 0);
    check("t4_c1_rv1", b_rv1, 0);
    check("t4_c1_mreq", b_mreq, 0);
    check("t4_c1_stall", b_stall, 1);
    tick; settle;
    check("t4_c2_rv1", b_rv1, 0);
    check("t4_c2_gnt0", b_gnt0, 0);
    tick;
    mem_rdata = 32'h1234_5678;
    settle;
    check("t4_c3_rv1", b_rv1, 1);
    check("t4_c3_rv0", b_rv0, 0);
    check("t4_c3_rdata", b_rdata, 32'h1234_5678);
    check("t4_c3_gnt0", b_gnt0, 0);
    tick;
    m1_req = 0; m1_addr = '0;
    settle;
    check("t4_c4_gnt0", b_gnt0, 1);
    check("t4_c4_maddr", b_maddr, 32'h50);
    check("t4_c4_rv1", b_rv1, 0);
    tick;
    m0_req = 0; m0_addr = '0;
    arstn = 1'b1;
    settle;
    arstn = 1'b0;

    // Reset pulse during WAIT aborts the access and restores m0 tie priority
    tick;
    m0_req = 1; m0_addr = 32'h60;
    settle;
    check("t5_gnt0", a_gnt0, 1);
    tick;
    arstn = 1'b1;
    #1;
    arstn = 1'b0;
    m0_req = 0; m0_addr = '0;
    settle;
    check("t5_w_rv0", a_rv0, 0);
    check("t5_w_rv1", a_rv1, 0);
    check("t5_w_mreq", a_mreq, 0);
    tick; settle;
    check("t5_after_rv0", a_rv0, 0);
    tick;
    m0_req = 1; m0_addr = 32'h70;
    m1_req = 1; m1_addr = 32'h80;
    settle;
    check("t5_tie_gnt0", a_gnt0, 1);
    check("t5_tie_gnt1", a_gnt1, 0);
    check("t5_tie_maddr", a_maddr, 32'h70);
    tick; settle;
    check("t5_tie_rv0", a_rv0, 1);
    tick;
    m0_req = 0; m1_req = 0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_dmem_arbiter.md
MIRISCV_DMEM_ARBITER -- requirements
Module: miriscv_dmem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk_i and arstn_i.
REQ-002 Parameter RD_LATENCY, default 1, SHALL give the memory read latency in cycles, legal range 1..4.
REQ-003 clk_i  in  1  clock; all state changes on the rising edge.
REQ-004 arstn_i  in  1  asynchronous reset, active-high.
REQ-005 m0_req_i  in  1  requester 0 (core LSU) access request.
REQ-006 m0_we_i  in  1  requester 0 write enable.
REQ-007 m0_be_i  in  4  requester 0 byte enables.
REQ-008 m0_addr_i  in  32  requester 0 byte address.
REQ-009 m0_wdata_i  in  32  requester 0 write data.
REQ-010 m0_gnt_o  out  1  requester 0 access accepted this cycle.
REQ-011 m0_rvalid_o  out  1  requester 0 access complete; rdata_o valid for reads.
REQ-012 m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o SHALL match REQ-005..REQ-011 for requester 1 (DMA or debug).
REQ-013 rdata_o  out  32  read data shared by both requesters; qualified by mN_rvalid_o.
REQ-014 core_stall_o  out  1  m0_req_i high and m0_rvalid_o low.
REQ-015 mem_req_o  out  1  memory access strobe, one cycle per access.
REQ-016 mem_we_o  out  1  memory write enable.
REQ-017 mem_be_o  out  4  memory byte enables.
REQ-018 mem_addr_o  out  32  memory byte address.
REQ-019 mem_wdata_o  out  32  memory write data.
REQ-020 mem_rdata_i  in  32  memory read data, valid RD_LATENCY cycles after mem_req_o.

Function
REQ-021 The FSM SHALL have two states: IDLE (arbitrate) and WAIT (one access outstanding).
REQ-022 In IDLE with one or more mN_req_i high, the block SHALL grant exactly one requester combinationally in the same cycle: mN_gnt_o=1 and mem_req_o=1, with mem_we/be/addr/wdata driven from that requester; the FSM SHALL then move to WAIT.
REQ-023 On simultaneous requests, the block SHALL grant the requester that was not granted last; the last-owner register SHALL be updated on every grant.
REQ-024 On grant, a latency counter SHALL load RD_LATENCY-1; in WAIT it SHALL decrement each cycle while nonzero.
REQ-025 In WAIT with the counter equal to 0, the block SHALL assert the owner's mN_rvalid_o for one cycle, drive rdata_o from mem_rdata_i, and return to IDLE; no grant SHALL occur in that cycle.
REQ-026 Writes SHALL follow the same timing as reads, including rvalid; rdata_o is don't-care for writes.
REQ-027 mem_req_o, mN_gnt_o and mN_rvalid_o SHALL be 0 in every cycle not listed above; mem_* data fields SHALL be 0 when mem_req_o is 0.
REQ-028 Requesters SHALL hold req and the access fields stable from assertion through their rvalid cycle; req still high in the cycle after rvalid SHALL be treated as a new access.
REQ-029 Requests arriving during WAIT SHALL be held off, with no gnt, until IDLE.
REQ-030 With RD_LATENCY=1, an access SHALL take 2 cycles (grant in N, rvalid in N+1); peak throughput SHALL be one access every 2 cycles.

Reset
REQ-031 Asserting arstn_i SHALL immediately force IDLE, counter 0, and last-owner = requester 1, so that requester 0 wins the first tie; all outputs SHALL be 0 except combinational grants in IDLE after release.
REQ-032 Reset during WAIT SHALL abort the in-flight access silently, with no rvalid afterwards.

Structure
REQ-033 The state typedef arb_state_t {IDLE, WAIT} SHALL be placed in riscv_pkg; RD_LATENCY SHALL remain a module parameter.
REQ-034 Two-way round-robin selection SHALL be a sub-module, miriscv_rr_arb2 (inputs req[1:0] and last; output one-hot gnt[1:0]).

Verification
REQ-035 After reset, m0 and m1 both request a read at addr 0x10/0x20 -> m0_gnt in cycle 0, mem_addr_o=0x10; m0_rvalid in cycle 1 with rdata_o=mem_rdata_i; m1_gnt in cycle 2.
REQ-036 Both requesters hold req continuously for 8 cycles -> grants alternate m0,m1,m0,m1 every 2 cycles; core_stall_o is high except in m0_rvalid cycles.
REQ-037 m0 write with be=4'b0100, wdata=0xAABBCCDD -> mem_we_o=1, mem_be_o=4'b0100, mem_wdata_o=0xAABBCCDD for exactly one cycle; m0_rvalid one cycle later.
REQ-038 RD_LATENCY=3, m1 read -> mem_req_o in cycle 0; m1_rvalid_o in cycle 3 only; m0 request raised in cycle 1 is granted in cycle 4.
REQ-039 arstn_i pulsed in the WAIT cycle -> no rvalid follows, state IDLE, and the next tie is granted to m0.
